rgb_pair_aligner: RTL and testbench
===================================

Name: rgb_pair_aligner

Overview:
- Upstream feeder for the two-input RGB weighted merge stage.
- Accepts two independent, bursty RGB pixel streams and buffers each in its own FIFO.
- Emits index-aligned pixel pairs with both valids asserted in the same cycle.
- Paces output so the merge stage, which accepts one pair per two cycles, never misses a pair.

Parameters:
- DEPTH, 16, entries per stream FIFO; power of two, 2..256.
- OUT_GAP, 1, minimum idle cycles between consecutive output pulses; range 0..15. Set to 1 when driving the merge stage.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- r1_in / g1_in / b1_in  in  8 each  stream-1 pixel.
- data1_valid  in  1  stream-1 pixel present this cycle.
- r2_in / g2_in / b2_in  in  8 each  stream-2 pixel.
- data2_valid  in  1  stream-2 pixel present this cycle.
- r1_out / g1_out / b1_out  out  8 each  aligned stream-1 pixel.
- r2_out / g2_out / b2_out  out  8 each  aligned stream-2 pixel.
- data1_out_valid  out  1  pair valid; always equal to data2_out_valid.
- data2_out_valid  out  1  pair valid.
- overflow1  out  1  sticky: a stream-1 pixel was dropped.
- overflow2  out  1  sticky: a stream-2 pixel was dropped.

Behaviour:
- Reset: all outputs 0, both FIFOs empty, FSM in IDLE, gap counter 0. Reset mid-burst discards all buffered pixels; no partial pair is emitted after release.
- Storage: two FIFOs, 24-bit entries {r,g,b}, DEPTH deep, with ADDR_W = log2(DEPTH) pointers plus an extra wrap bit. Pointers wrap modulo DEPTH.
- Push: dataN_valid=1 pushes at the clock edge if countN < DEPTH, or if a pop of that FIFO happens in the same cycle. Simultaneous push and pop on a full FIFO is legal; count stays DEPTH.
- Drop: a push into a full FIFO with no same-cycle pop drops the pixel. overflowN then sets and stays set until reset. FIFO contents are unchanged.
- FSM states:
  - IDLE: if count1>0 and count2>0, pop both heads, register them onto the outputs, and assert both out_valids for exactly one cycle. Then go to GAP if OUT_GAP>0 (loading the gap counter with OUT_GAP); otherwise stay in IDLE, allowing back-to-back pairs.
  - GAP: out_valids are 0; the counter decrements each cycle. Return to IDLE in the cycle the counter reaches 1.
- Outputs hold the last popped pair when valid is 0; they are not cleared.
- Latency: a pixel pushed at edge E, into an otherwise empty FIFO whose partner FIFO is already non-empty, appears with valid high after edge E+1. Two-cycle input-to-output latency.
- Throughput: at most one pair per (OUT_GAP+1) cycles.
- Pairing: strictly by arrival order. The k-th stream-1 pixel always pairs with the k-th stream-2 pixel, unless a drop occurred.
- Imbalance: if one stream runs ahead, its FIFO fills, then drops and flags. The other stream is unaffected.
- Empty/stall: no output while either FIFO is empty. The FSM stays in IDLE indefinitely.

Optional Feature:
- Macro: RGB_PAIR_ALIGNER_FLUSH_EN.
- Defined: adds input port flush (1 bit). flush=1 at an edge synchronously empties both FIFOs, clears both overflow flags, forces IDLE and gap counter 0, and suppresses any pop or push in that cycle. Output data registers are untouched and out_valids are 0 in the following cycle.
- Undefined: no flush port. Only rst_n clears state.

Decomposition:
- Shared package holds:
  - RGB pixel typedef: packed struct {r,g,b}, 8 bits each.
  - FSM state enum: IDLE, GAP.
  - Constant PIX_W = 24.
- One natural sub-module: rgb_pix_fifo, a single-clock FIFO with push/pop/count/full/empty. It is instantiated twice with DEPTH.
- FSM, pacing counter and overflow flags live in the top.

Test Plan:
- Lockstep streams, OUT_GAP=1: both valids high for 4 cycles with pixels (10,20,30)/(40,50,60) incrementing by 1. Expect 4 pairs on cycles 2,4,6,8 after first push; first pair is (10,20,30)/(40,50,60), in order; no overflow.
- Skewed arrival: stream-1 sends 3 pixels at cycles 0–2, stream-2 sends 3 pixels at cycles 10–12. Expect first pair valid at cycle 12, then pairs at cycles 14 and 16, correctly matched.
- Overflow, DEPTH=4: stream-1 sends 6 pixels, stream-2 sends none. Expect overflow1=1 from the 5th pixel and overflow2=0. Then send 4 stream-2 pixels and expect stream-1 pixels 1–4 paired; pixels 5–6 are lost.
- Full with simultaneous push and pop: DEPTH=4, both FIFOs full, OUT_GAP=0, both valids high continuously. Expect a pair every cycle and no overflow.
- Reset mid-burst: assert rst_n=0 with 3 pairs buffered. Expect all outputs 0 and no pair emitted after release until new data arrives on both streams.
- RGB_PAIR_ALIGNER_FLUSH_EN: with overflow1=1 and 2 pixels buffered, pulse flush. Expect flags cleared, no pair emitted, and subsequent pairing to start fresh from the next pixels.

Source files
------------

// File: rtl/rgb_pair_aligner_pkg.sv
// Shared types and constants for the RGB pair aligner: pixel struct, FSM state codes, pixel width.
package rgb_pair_aligner_pkg;

  localparam int PIX_W = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_pix_t;

  typedef logic [0:0] state_t;

  localparam state_t IDLE = 1'b0;
  localparam state_t GAP  = 1'b1;

endpackage

// File: rtl/rgb_pix_fifo.sv
// Single-clock pixel FIFO with wrap-bit pointers; clear_i empties it synchronously.
module rgb_pix_fifo
  import rgb_pair_aligner_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     clear_i,
  input  logic     push_i,
  input  logic     pop_i,
  input  rgb_pix_t data_i,
  output rgb_pix_t data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  rgb_pix_t        mem_q [DEPTH];
  logic [ADDR_W:0] wrPtr_q, wrPtr_d;
  logic [ADDR_W:0] rdPtr_q, rdPtr_d;
  logic [ADDR_W:0] count;
  logic            doPush;
  logic            doPop;

  assign count   = wrPtr_q - rdPtr_q;
  assign full_o  = (count == FULL_CNT);
  assign empty_o = (count == '0);
  assign data_o  = mem_q[rdPtr_q[ADDR_W-1:0]];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign doPop  = pop_i & ~empty_o & ~clear_i;
  assign doPush = push_i & (~full_o | doPop) & ~clear_i;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (clear_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + 1'b1;
      if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q[ADDR_W-1:0]] <= data_i;
  end

endmodule

// File: rtl/rgb_pair_aligner.sv
// Buffers two bursty RGB streams and emits index-aligned pairs paced by OUT_GAP idle cycles.
// Optional synchronous flush port enabled with `define RGB_PAIR_ALIGNER_FLUSH_EN.
module rgb_pair_aligner
  import rgb_pair_aligner_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int OUT_GAP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef RGB_PAIR_ALIGNER_FLUSH_EN
  input  logic       flush,
`endif
  input  logic [7:0] r1_in,
  input  logic [7:0] g1_in,
  input  logic [7:0] b1_in,
  input  logic       data1_valid,
  input  logic [7:0] r2_in,
  input  logic [7:0] g2_in,
  input  logic [7:0] b2_in,
  input  logic       data2_valid,
  output logic [7:0] r1_out,
  output logic [7:0] g1_out,
  output logic [7:0] b1_out,
  output logic [7:0] r2_out,
  output logic [7:0] g2_out,
  output logic [7:0] b2_out,
  output logic       data1_out_valid,
  output logic       data2_out_valid,
  output logic       overflow1,
  output logic       overflow2
);

  localparam logic [3:0] GAP_LOAD = 4'(OUT_GAP);

  logic     flushW;
  rgb_pix_t in1, in2;
  rgb_pix_t head1, head2;
  logic     full1, full2;
  logic     empty1, empty2;
  logic     popPair;

  state_t     state_q, state_d;
  logic [3:0] gap_q, gap_d;
  logic       valid_q, valid_d;
  rgb_pix_t   out1_q, out1_d;
  rgb_pix_t   out2_q, out2_d;
  logic       ovf1_q, ovf1_d;
  logic       ovf2_q, ovf2_d;

`ifdef RGB_PAIR_ALIGNER_FLUSH_EN
  assign flushW = flush;
`else
  assign flushW = 1'b0;
`endif

  assign in1 = '{r: r1_in, g: g1_in, b: b1_in};
  assign in2 = '{r: r2_in, g: g2_in, b: b2_in};

  assign popPair = (state_q == IDLE) & ~empty1 & ~empty2 & ~flushW;

  rgb_pix_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (flushW),
    .push_i  (data1_valid & ~flushW),
    .pop_i   (popPair),
    .data_i  (in1),
    .data_o  (head1),
    .full_o  (full1),
    .empty_o (empty1)
  );

  rgb_pix_fifo #(.DEPTH(DEPTH)) u_fifo2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (flushW),
    .push_i  (data2_valid & ~flushW),
    .pop_i   (popPair),
    .data_i  (in2),
    .data_o  (head2),
    .full_o  (full2),
    .empty_o (empty2)
  );

  // Pair emission and pacing; output data holds its last value while valid is low.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    valid_d = 1'b0;
    out1_d  = out1_q;
    out2_d  = out2_q;
    ovf1_d  = ovf1_q | (data1_valid & full1 & ~popPair);
    ovf2_d  = ovf2_q | (data2_valid & full2 & ~popPair);
    if (flushW) begin
      state_d = IDLE;
      gap_d   = '0;
      ovf1_d  = 1'b0;
      ovf2_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (popPair) begin
            valid_d = 1'b1;
            out1_d  = head1;
            out2_d  = head2;
            if (OUT_GAP > 0) begin
              state_d = GAP;
              gap_d   = GAP_LOAD;
            end
          end
        end
        GAP: begin
          if (gap_q <= 4'd1) begin
            state_d = IDLE;
            gap_d   = '0;
          end else begin
            gap_d = gap_q - 4'd1;
          end
        end
        default: begin
          state_d = IDLE;
          gap_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gap_q   <= '0;
      valid_q <= 1'b0;
      out1_q  <= '0;
      out2_q  <= '0;
      ovf1_q  <= 1'b0;
      ovf2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      ovf1_q  <= ovf1_d;
      ovf2_q  <= ovf2_d;
    end
  end

  assign r1_out          = out1_q.r;
  assign g1_out          = out1_q.g;
  assign b1_out          = out1_q.b;
  assign r2_out          = out2_q.r;
  assign g2_out          = out2_q.g;
  assign b2_out          = out2_q.b;
  assign data1_out_valid = valid_q;
  assign data2_out_valid = valid_q;
  assign overflow1       = ovf1_q;
  assign overflow2       = ovf2_q;

endmodule

// File: tb/tb_rgb_pair_aligner.sv
// Directed scoreboard bench: instance A (DEPTH=4, OUT_GAP=1) and instance B (DEPTH=4, OUT_GAP=0).
module tb_rgb_pair_aligner;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        v1A, v2A, v1B, v2B;
  logic [23:0] p1A, p2A, p1B, p2B;
  logic [7:0]  r1A, g1A, b1A, r2A, g2A, b2A;
  logic [7:0]  r1B, g1B, b1B, r2B, g2B, b2B;
  logic        vo1A, vo2A, vo1B, vo2B;
  logic        ov1A, ov2A, ov1B, ov2B;
`ifdef RGB_PAIR_ALIGNER_FLUSH_EN
  logic        flushA = 1'b0;
  logic        flushB = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int pairsA = 0;
  int pairsB = 0;
  int cycA = 0;
  int lastA = -100;
  int base;
  logic [47:0] expA[$];
  logic [47:0] expB[$];
  logic [47:0] got;

  rgb_pair_aligner #(.DEPTH(DEPTH), .OUT_GAP(1)) dutA (
    .clk(clk), .rst_n(rst_n),
`ifdef RGB_PAIR_ALIGNER_FLUSH_EN
    .flush(flushA),
`endif
    .r1_in(p1A[23:16]), .g1_in(p1A[15:8]), .b1_in(p1A[7:0]), .data1_valid(v1A),
    .r2_in(p2A[23:16]), .g2_in(p2A[15:8]), .b2_in(p2A[7:0]), .data2_valid(v2A),
    .r1_out(r1A), .g1_out(g1A), .b1_out(b1A),
    .r2_out(r2A), .g2_out(g2A), .b2_out(b2A),
    .data1_out_valid(vo1A), .data2_out_valid(vo2A),
    .overflow1(ov1A), .overflow2(ov2A)
  );

  rgb_pair_aligner #(.DEPTH(DEPTH), .OUT_GAP(0)) dutB (
    .clk(clk), .rst_n(rst_n),
`ifdef RGB_PAIR_ALIGNER_FLUSH_EN
    .flush(flushB),
`endif
    .r1_in(p1B[23:16]), .g1_in(p1B[15:8]), .b1_in(p1B[7:0]), .data1_valid(v1B),
    .r2_in(p2B[23:16]), .g2_in(p2B[15:8]), .b2_in(p2B[7:0]), .data2_valid(v2B),
    .r1_out(r1B), .g1_out(g1B), .b1_out(b1B),
    .r2_out(r2B), .g2_out(g2B), .b2_out(b2B),
    .data1_out_valid(vo1B), .data2_out_valid(vo2B),
    .overflow1(ov1B), .overflow2(ov2B)
  );

  function automatic logic [23:0] pix(input int v);
    return {8'(v), 8'(v + 1), 8'(v + 2)};
  endfunction

  task automatic checkOutput(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic a1, input logic [23:0] d1, input logic a2, input logic [23:0] d2);
    v1A = a1; p1A = d1; v2A = a2; p2A = d2;
    @(posedge clk); #1;
    v1A = 1'b0; v2A = 1'b0;
  endtask

  task automatic applyStimulusB(input logic a1, input logic [23:0] d1, input logic a2, input logic [23:0] d2);
    v1B = a1; p1B = d1; v2B = a2; p2B = d2;
    @(posedge clk); #1;
    v1B = 1'b0; v2B = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard for instance A: pair order, valid agreement, minimum pacing.
  always @(negedge clk) begin
    if (rst_n) begin
      cycA++;
      if (vo1A || vo2A) begin
        checkOutput("validEqA", 48'(vo1A), 48'(vo2A));
        pairsA++;
        checkOutput("gapA", 48'((cycA - lastA) >= 2), 48'd1);
        lastA = cycA;
        checkOutput("queueA", 48'(expA.size() > 0), 48'd1);
        if (expA.size() > 0) begin
          got = {r1A, g1A, b1A, r2A, g2A, b2A};
          checkOutput("pairA", got, expA.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && (vo1B || vo2B)) begin
      checkOutput("validEqB", 48'(vo1B), 48'(vo2B));
      pairsB++;
      checkOutput("queueB", 48'(expB.size() > 0), 48'd1);
      if (expB.size() > 0) begin
        got = {r1B, g1B, b1B, r2B, g2B, b2B};
        checkOutput("pairB", got, expB.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    v1A = 0; v2A = 0; p1A = '0; p2A = '0;
    v1B = 0; v2B = 0; p1B = '0; p2B = '0;
    idle(2);
    checkOutput("rstValid", 48'(vo1A), 48'd0);
    checkOutput("rstData", {r1A, g1A, b1A, r2A, g2A, b2A}, 48'd0);
    checkOutput("rstOvf", 48'({ov1A, ov2A}), 48'd0);
    rst_n = 1'b1;
    idle(1);

    $display("[TB] lockstep streams");
    for (int k = 0; k < 4; k++) begin
      expA.push_back({8'(10 + k), 8'(20 + k), 8'(30 + k), 8'(40 + k), 8'(50 + k), 8'(60 + k)});
      applyStimulus(1'b1, {8'(10 + k), 8'(20 + k), 8'(30 + k)}, 1'b1, {8'(40 + k), 8'(50 + k), 8'(60 + k)});
      if (k == 0) checkOutput("latPre", 48'(vo1A), 48'd0);
      if (k == 1) begin
        checkOutput("latFirst", 48'(vo1A), 48'd1);
        checkOutput("firstPair", {r1A, g1A, b1A, r2A, g2A, b2A}, 48'h0a141e28323c);
      end
    end
    idle(10);
    checkOutput("lockDrain", 48'(expA.size()), 48'd0);
    checkOutput("lockPairs", 48'(pairsA), 48'd4);
    checkOutput("lockOvf", 48'({ov1A, ov2A}), 48'd0);

    $display("[TB] skewed arrival");
    base = pairsA;
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, pix(70 + 3 * k), 1'b0, '0);
    idle(7);
    for (int k = 0; k < 3; k++) begin
      expA.push_back({pix(70 + 3 * k), pix(130 + 3 * k)});
      applyStimulus(1'b0, '0, 1'b1, pix(130 + 3 * k));
      if (k == 0) checkOutput("skewPre", 48'(vo1A), 48'd0);
      if (k == 1) checkOutput("skewFirst", 48'(vo1A), 48'd1);
    end
    idle(10);
    checkOutput("skewDrain", 48'(expA.size()), 48'd0);
    checkOutput("skewPairs", 48'(pairsA - base), 48'd3);

    $display("[TB] stream-1 overflow");
    base = pairsA;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, pix(100 + 3 * k), 1'b0, '0);
      if (k == 3) checkOutput("ovfBefore", 48'(ov1A), 48'd0);
      if (k == 4) checkOutput("ovfSet", 48'(ov1A), 48'd1);
    end
    checkOutput("ovf2Clear", 48'(ov2A), 48'd0);
    for (int k = 0; k < 4; k++) begin
      expA.push_back({pix(100 + 3 * k), pix(200 + 3 * k)});
      applyStimulus(1'b0, '0, 1'b1, pix(200 + 3 * k));
    end
    idle(12);
    checkOutput("ovfDrain", 48'(expA.size()), 48'd0);
    checkOutput("ovfPairs", 48'(pairsA - base), 48'd4);
    checkOutput("ovfSticky", 48'({ov1A, ov2A}), 48'b10);

    $display("[TB] reset mid-burst");
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, pix(150 + 3 * k), 1'b0, '0);
    rst_n = 1'b0;
    #2;
    checkOutput("midRstValid", 48'(vo1A), 48'd0);
    checkOutput("midRstData", {r1A, g1A, b1A, r2A, g2A, b2A}, 48'd0);
    checkOutput("midRstOvf", 48'({ov1A, ov2A}), 48'd0);
    idle(2);
    rst_n = 1'b1;
    base = pairsA;
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, '0, 1'b1, pix(160 + 3 * k));
    idle(6);
    checkOutput("rstNoPair", 48'(pairsA - base), 48'd0);
    for (int k = 0; k < 3; k++) begin
      expA.push_back({pix(30 + 3 * k), pix(160 + 3 * k)});
      applyStimulus(1'b1, pix(30 + 3 * k), 1'b0, '0);
    end
    idle(10);
    checkOutput("rstDrain", 48'(expA.size()), 48'd0);
    checkOutput("rstPairs", 48'(pairsA - base), 48'd3);

    $display("[TB] full FIFO with same-cycle push and pop");
    for (int k = 0; k < 4; k++) applyStimulusB(1'b1, pix(k * 3), 1'b0, '0);
    expB.push_back({pix(0), pix(90)});
    applyStimulusB(1'b0, '0, 1'b1, pix(90));
    for (int k = 1; k < 9; k++) begin
      expB.push_back({pix(k * 3), pix(90 + k * 3)});
      applyStimulusB(1'b1, pix((k + 3) * 3), 1'b1, pix(90 + k * 3));
      checkOutput("fullEvery", 48'(vo1B), 48'd1);
    end
    idle(4);
    checkOutput("fullDrain", 48'(expB.size()), 48'd0);
    checkOutput("fullPairs", 48'(pairsB), 48'd9);
    checkOutput("fullOvf", 48'({ov1B, ov2B}), 48'd0);

`ifdef RGB_PAIR_ALIGNER_FLUSH_EN
    $display("[TB] flush");
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, pix(180 + 3 * k), 1'b0, '0);
    checkOutput("preFlushOvf", 48'(ov1A), 48'd1);
    flushA = 1'b1;
    @(posedge clk); #1;
    flushA = 1'b0;
    checkOutput("flushOvf", 48'({ov1A, ov2A}), 48'd0);
    checkOutput("flushValid", 48'(vo1A), 48'd0);
    base = pairsA;
    for (int k = 0; k < 2; k++) applyStimulus(1'b0, '0, 1'b1, pix(220 + 3 * k));
    idle(5);
    checkOutput("flushNoPair", 48'(pairsA - base), 48'd0);
    for (int k = 0; k < 2; k++) begin
      expA.push_back({pix(240 + 3 * k), pix(220 + 3 * k)});
      applyStimulus(1'b1, pix(240 + 3 * k), 1'b0, '0);
    end
    idle(8);
    checkOutput("flushDrain", 48'(expA.size()), 48'd0);
    checkOutput("flushPairs", 48'(pairsA - base), 48'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
